// File: rtl/bitfusion_pkg.sv
// Shared encodings for the input fetch path: weight bitwidth codes,
// phases per 32-bit buffer word, and the fetch sequencer state codes.
package bitfusion_pkg;

  // Weight bitwidth encodings as seen on cfg_bitwidth / mux_bitwidth.
  localparam logic [1:0] BW_8       = 2'b00;
  localparam logic [1:0] BW_4       = 2'b01;
  localparam logic [1:0] BW_2       = 2'b10;
  localparam logic [1:0] BW_ILLEGAL = 2'b11;

  // Fetch sequencer state encoding.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PRIME = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // Number of mux phases needed to consume one 32-bit buffer word.
  function automatic logic [2:0] phases_per_word(input logic [1:0] bw);
    case (bw)
      BW_4:    return 3'd2;
      BW_2:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Modulo-P phase counter (P = 1, 2 or 4) with a combinational wrap flag
// that marks the last phase of the current buffer word.
module phase_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic [2:0] i_phases,
  output logic       o_wrap
);

  logic [1:0] r_phase;
  logic [1:0] w_last_phase;

  assign w_last_phase = 2'(i_phases - 3'd1);
  assign o_wrap       = (r_phase == w_last_phase);

  // Count phases while enabled, returning to 0 after the last phase.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_phase <= 2'd0;
    end else if (i_en) begin
      r_phase <= o_wrap ? 2'd0 : r_phase + 2'd1;
    end
  end

endmodule

// File: rtl/input_fetch_sequencer.sv
// Input fetch sequencer: streams cfg_len buffer words starting at cfg_base
// into the input mux stage, spending 1/2/4 mux phases per word depending
// on the weight bitwidth, and flags valid/last sorted data one cycle later.
module input_fetch_sequencer
  import bitfusion_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        cfg_bitwidth,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [1:0]        mux_bitwidth,
  output logic              mux_reset,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [1:0]        r_state;
  logic [1:0]        r_bitwidth;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_word;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_err;

  logic              w_in_run;
  logic              w_wrap;
  logic              w_last_word;
  logic              w_final;
  logic [2:0]        w_phases;

  assign w_in_run    = (r_state == ST_RUN);
  assign w_phases    = phases_per_word(r_bitwidth);
  assign w_last_word = (r_word == r_len - LEN_W'(1));
  assign w_final     = w_in_run && w_wrap && w_last_word;

  phase_counter u_phase_counter (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (!w_in_run),
    .i_en     (w_in_run),
    .i_phases (w_phases),
    .o_wrap   (w_wrap)
  );

  // Job FSM: accepts start in IDLE only, abort wins over start and ends PRIME/RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bitwidth <= BW_8;
      r_base     <= '0;
      r_len      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            if (cfg_bitwidth == BW_ILLEGAL) begin
              r_err <= 1'b1;
            end else if (cfg_len == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_bitwidth <= cfg_bitwidth;
              r_base     <= cfg_base;
              r_len      <= cfg_len;
              r_state    <= ST_PRIME;
            end
          end
        end
        ST_PRIME: r_state <= abort ? ST_IDLE : ST_RUN;
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (w_final) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Word counter: cleared outside RUN, advances on the last phase of each word.
  always_ff @(posedge clk) begin
    if (reset || !w_in_run) begin
      r_word <= '0;
    end else if (w_wrap && !w_last_word) begin
      r_word <= r_word + LEN_W'(1);
    end
  end

  // Valid/last trail RUN by one cycle to line up with the mux register stage;
  // an abort drops the beat that would have emerged next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= w_in_run && !abort;
      r_out_last  <= w_final && !abort;
    end
  end

  // Buffer read strobe and address: base in PRIME, next word on the last phase in RUN.
  // NOTE: every output of this always_comb gets a default first so no latch is inferred.
  always_comb begin
    buf_rd_en = 1'b0;
    buf_addr  = '0;
    case (r_state)
      ST_PRIME: begin
        buf_rd_en = !abort;
        buf_addr  = r_base;
      end
      ST_RUN: begin
        buf_rd_en = w_wrap && !w_last_word && !abort;
        buf_addr  = r_base + ADDR_W'(r_word) + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign mux_bitwidth = r_bitwidth;
  assign mux_reset    = !w_in_run;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign err          = r_err;

endmodule

// File: tb/tb_input_fetch_sequencer.sv
// Directed bench for input_fetch_sequencer: a table of jobs with
// hand-computed timing, plus abort / start-while-busy / reset-mid-job
// sequences. A small buffer + mux-stage model checks the sorted data.
module tb_input_fetch_sequencer;

  localparam int MAX_C = 14;
  localparam int INJ_NONE  = 0;
  localparam int INJ_ABORT = 1;
  localparam int INJ_START = 2;
  localparam int INJ_RESET = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] cfg_bitwidth = 2'b00;
  logic [7:0] cfg_base = 8'h00;
  logic [7:0] cfg_len = 8'h00;
  logic       buf_rd_en;
  logic [7:0] buf_addr;
  logic [1:0] mux_bitwidth;
  logic       mux_reset;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       err;

  input_fetch_sequencer #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .cfg_bitwidth (cfg_bitwidth),
    .cfg_base     (cfg_base),
    .cfg_len      (cfg_len),
    .buf_rd_en    (buf_rd_en),
    .buf_addr     (buf_addr),
    .mux_bitwidth (mux_bitwidth),
    .mux_reset    (mux_reset),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // ---------------- buffer and mux-stage reference ----------------
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {~a, a ^ 8'hA5, a + 8'h3C, a};
  endfunction

  function automatic int nph(input logic [1:0] bw);
    case (bw)
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] slice_of(input logic [31:0] w, input int ph, input logic [1:0] bw);
    case (bw)
      2'b00:   return w;
      2'b01:   return (w >> (16 * ph)) & 32'h0000_FFFF;
      2'b10:   return (w >> (8 * ph)) & 32'h0000_00FF;
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] m_data = 32'h0;
  logic [31:0] m_sorted = 32'h0;
  int          m_phase = 0;

  always @(posedge clk) begin
    if (buf_rd_en) m_data <= mem_word(buf_addr);
    if (mux_reset) m_phase <= 0;
    else           m_phase <= (m_phase + 1) % nph(mux_bitwidth);
    m_sorted <= slice_of(m_data, m_phase, mux_bitwidth);
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] snap_outputs();
    return {buf_rd_en, buf_addr, mux_bitwidth, mux_reset, out_valid, out_last, busy, done, err};
  endfunction

  typedef struct {
    logic [1:0] bw;
    logic [7:0] base;
    logic [7:0] len;
    int         n_reads;
    int         rd0_t;  logic [7:0] rd0_a;
    int         rd1_t;  logic [7:0] rd1_a;
    int         rd2_t;  logic [7:0] rd2_a;
    int         n_valid;
    int         v_first;
    int         v_last;
    int         last_t;
    int         done_t;
    int         err_t;
    int         n_busy;
    int         n_mrst;
  } vec_t;

  // per-job observations (cycle numbers are relative to the start cycle T)
  int          n_reads, n_valid, v_first, v_last, n_last, last_t;
  int          n_done, done_t, n_err, err_t, n_busy, n_mrst, bw_bad, data_bad;
  int          rd_t [0:7];
  logic [7:0]  rd_a [0:7];
  logic [17:0] snap [0:MAX_C];

  task automatic run_job(input vec_t v, input int inj, input int inj_c);
    @(posedge clk); #1;
    cfg_bitwidth = v.bw; cfg_base = v.base; cfg_len = v.len;
    start = 1'b1;
    abort = (inj == INJ_ABORT && inj_c == 0);
    n_reads = 0; n_valid = 0; v_first = 0; v_last = 0; n_last = 0; last_t = 0;
    n_done = 0; done_t = 0; n_err = 0; err_t = 0; n_busy = 0; n_mrst = 0;
    bw_bad = 0; data_bad = 0;
    for (int c = 1; c <= MAX_C; c++) begin
      @(posedge clk); #1;
      start = (inj == INJ_START && c == inj_c);
      if (start) begin
        cfg_bitwidth = 2'b01; cfg_base = 8'h55; cfg_len = 8'd5;
      end
      abort = (inj == INJ_ABORT && c == inj_c);
      reset = (inj == INJ_RESET && c == inj_c);
      @(negedge clk);
      snap[c] = snap_outputs();
      if (buf_rd_en) begin
        if (n_reads < 8) begin
          rd_t[n_reads] = c;
          rd_a[n_reads] = buf_addr;
        end
        n_reads++;
      end
      if (out_valid) begin
        logic [7:0] a;
        a = v.base + 8'(n_valid / nph(v.bw));
        if (m_sorted !== slice_of(mem_word(a), n_valid % nph(v.bw), v.bw)) data_bad++;
        if (n_valid == 0) v_first = c;
        v_last = c;
        n_valid++;
      end
      if (out_last) begin n_last++; last_t = c; end
      if (done)     begin n_done++; done_t = c; end
      if (err)      begin n_err++;  err_t = c;  end
      if (busy) begin
        n_busy++;
        if (mux_reset) n_mrst++;
        if (v.len != 8'd0 && mux_bitwidth !== v.bw) bw_bad++;
      end
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0;
  endtask

  vec_t vecs [0:5];
  vec_t hv;

  initial begin
    //        bw     base   len  rd  rd0        rd1        rd2       nv vf vl  lt dt et  nb nm
    vecs[0] = '{2'b00, 8'h10, 8'd3, 3, 1, 8'h10, 2, 8'h11, 3, 8'h12, 3, 3, 5,  5, 5, 0, 5, 2};
    vecs[1] = '{2'b01, 8'h00, 8'd2, 2, 1, 8'h00, 3, 8'h01, 0, 8'h00, 4, 3, 6,  6, 6, 0, 6, 2};
    vecs[2] = '{2'b10, 8'hFF, 8'd2, 2, 1, 8'hFF, 5, 8'h00, 0, 8'h00, 8, 3, 10, 10, 10, 0, 10, 2};
    vecs[3] = '{2'b11, 8'h20, 8'd3, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0,  0, 0, 1, 0, 0};
    vecs[4] = '{2'b00, 8'h40, 8'd0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0,  0, 1, 0, 1, 1};
    vecs[5] = '{2'b01, 8'h7E, 8'd3, 3, 1, 8'h7E, 3, 8'h7F, 5, 8'h80, 6, 3, 8,  8, 8, 0, 8, 2};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'(snap_outputs()),
          64'({1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // table-driven jobs
    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i], INJ_NONE, 0);
      check($sformatf("j%0d_reads", i), 64'(n_reads), 64'(vecs[i].n_reads));
      if (vecs[i].n_reads > 0)
        check($sformatf("j%0d_rd0", i), {24'h0, rd_t[0], rd_a[0]}, {24'h0, vecs[i].rd0_t, vecs[i].rd0_a});
      if (vecs[i].n_reads > 1)
        check($sformatf("j%0d_rd1", i), {24'h0, rd_t[1], rd_a[1]}, {24'h0, vecs[i].rd1_t, vecs[i].rd1_a});
      if (vecs[i].n_reads > 2)
        check($sformatf("j%0d_rd2", i), {24'h0, rd_t[2], rd_a[2]}, {24'h0, vecs[i].rd2_t, vecs[i].rd2_a});
      check($sformatf("j%0d_nvalid", i), 64'(n_valid), 64'(vecs[i].n_valid));
      check($sformatf("j%0d_vfirst", i), 64'(v_first), 64'(vecs[i].v_first));
      check($sformatf("j%0d_vlast", i),  64'(v_last),  64'(vecs[i].v_last));
      check($sformatf("j%0d_last_t", i), 64'(last_t),  64'(vecs[i].last_t));
      check($sformatf("j%0d_nlast", i),  64'(n_last),  64'(vecs[i].last_t != 0));
      check($sformatf("j%0d_done_t", i), 64'(done_t),  64'(vecs[i].done_t));
      check($sformatf("j%0d_ndone", i),  64'(n_done),  64'(vecs[i].done_t != 0));
      check($sformatf("j%0d_err_t", i),  64'(err_t),   64'(vecs[i].err_t));
      check($sformatf("j%0d_nbusy", i),  64'(n_busy),  64'(vecs[i].n_busy));
      check($sformatf("j%0d_mrst", i),   64'(n_mrst),  64'(vecs[i].n_mrst));
      check($sformatf("j%0d_bw", i),     64'(bw_bad),  64'd0);
      check($sformatf("j%0d_data", i),   64'(data_bad), 64'd0);
    end

    // abort on the 2nd RUN cycle of a 2-bit len-4 job
    hv = '{2'b10, 8'h30, 8'd4, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0};
    run_job(hv, INJ_ABORT, 3);
    check("abort_reads", 64'(n_reads), 64'd1);
    check("abort_rd0", {24'h0, rd_t[0], rd_a[0]}, {24'h0, 32'd1, 8'h30});
    check("abort_ndone", 64'(n_done), 64'd0);
    check("abort_nbusy", 64'(n_busy), 64'd3);
    check("abort_nvalid", 64'(n_valid), 64'd1);
    check("abort_next", 64'(snap[4]),
          64'({1'b0, 8'h00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    check("abort_data", 64'(data_bad), 64'd0);

    // start pulse while busy must not disturb the running 8-bit job
    run_job(vecs[0], INJ_START, 2);
    check("sbusy_reads", 64'(n_reads), 64'd3);
    check("sbusy_rd2", {24'h0, rd_t[2], rd_a[2]}, {24'h0, 32'd3, 8'h12});
    check("sbusy_done_t", 64'(done_t), 64'd5);
    check("sbusy_ndone", 64'(n_done), 64'd1);
    check("sbusy_nbusy", 64'(n_busy), 64'd5);
    check("sbusy_bw", 64'(bw_bad), 64'd0);

    // reset in the middle of RUN discards the job
    run_job(hv, INJ_RESET, 3);
    check("rst_outputs", 64'(snap[4]),
          64'({1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    check("rst_ndone", 64'(n_done), 64'd0);
    check("rst_nbusy", 64'(n_busy), 64'd3);
    check("rst_reads", 64'(n_reads), 64'd1);

    // abort together with start in IDLE: start is dropped
    hv = '{2'b00, 8'h60, 8'd2, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0};
    run_job(hv, INJ_ABORT, 0);
    check("abst_nbusy", 64'(n_busy), 64'd0);
    check("abst_reads", 64'(n_reads), 64'd0);
    check("abst_nerr", 64'(n_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
